// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default sizes, complex word type,
// read-side FSM states and the bit-reversal helper.
package fft_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FFT_POINTS = 16;
    localparam int DEF_LOG2N      = $clog2(DEF_FFT_POINTS);

    // [0]=real, [1]=imag
    typedef logic signed [1:0][DEF_DATA_WIDTH-1:0] cplx_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < nbits; i++) begin
            r = r | (((idx >> i) & 32'd1) << (nbits - 1 - i));
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pp_bank.sv
// One ping-pong bank: even/odd arrays written together at the pair address,
// read asynchronously from either half.
module fft_pp_bank
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [AW-1:0]              waddr_i,
    input  logic [1:0][DATA_WIDTH-1:0] even_i,
    input  logic [1:0][DATA_WIDTH-1:0] odd_i,
    input  logic [AW-1:0]              raddr_i,
    input  logic                       rodd_i,
    output logic [1:0][DATA_WIDTH-1:0] rdata_o
);

    logic [1:0][DATA_WIDTH-1:0] even_mem [DEPTH];
    logic [1:0][DATA_WIDTH-1:0] odd_mem  [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            even_mem[waddr_i] <= even_i;
            odd_mem[waddr_i]  <= odd_i;
        end
    end

    assign rdata_o = rodd_i ? odd_mem[raddr_i] : even_mem[raddr_i];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong reorder buffer: butterfly pairs arrive in bit-reversed order,
// X[k] leaves in natural order over a valid/ready stream.
module fft_bitrev_buffer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int FFT_POINTS = 16
) (
    input  logic                       clk_i,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [1:0][DATA_WIDTH-1:0] a_i,
    input  logic [1:0][DATA_WIDTH-1:0] b_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [1:0][DATA_WIDTH-1:0] out_data_o,
    output logic                       out_last_o,
    output logic                       overflow_o
);

    localparam int LOG2N = $clog2(FFT_POINTS);
    localparam int HALF  = FFT_POINTS / 2;
    localparam int PW    = LOG2N - 1;

    if (FFT_POINTS < 4 || (1 << LOG2N) != FFT_POINTS || FRAC_BITS >= DATA_WIDTH) begin : g_bad_cfg
        $error("fft_bitrev_buffer: unsupported parameter set");
    end

    logic                       wr_bank_q, wr_bank_d;
    logic [PW-1:0]              p_q, p_d;
    logic [1:0]                 full_q, full_d;
    logic                       ovf_q, ovf_d;
    logic                       rd_bank_q, rd_bank_d;
    rd_state_e                  state_q, state_d;
    logic [LOG2N-1:0]           k_q, k_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic [1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                       in_ready;
    logic                       wr_fire;
    logic [LOG2N-1:0]           j;
    logic [1:0][1:0][DATA_WIDTH-1:0] rdata;

    assign in_ready = !full_q[wr_bank_q];
    assign wr_fire  = in_valid_i && in_ready;
    assign j        = LOG2N'(bitrev(32'(k_q), LOG2N));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_pp_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (HALF),
            .AW        (PW)
        ) u_bank (
            .clk_i  (clk_i),
            .we_i   (wr_fire && (wr_bank_q == 1'(b))),
            .waddr_i(p_q),
            .even_i (a_i),
            .odd_i  (b_i),
            .raddr_i(j[LOG2N-1:1]),
            .rodd_i (j[0]),
            .rdata_o(rdata[b])
        );
    end

    always_comb begin
        wr_bank_d   = wr_bank_q;
        p_d         = p_q;
        full_d      = full_q;
        ovf_d       = ovf_q;
        rd_bank_d   = rd_bank_q;
        state_d     = state_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (in_valid_i && !in_ready) ovf_d = 1'b1;

        if (wr_fire) begin
            if (p_q == PW'(HALF - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                p_d               = '0;
            end else begin
                p_d = p_q + 1'b1;
            end
        end

        // Reader only touches full banks, so its clear never collides with the writer's set.
        case (state_q)
            RD_IDLE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (full_q[rd_bank_q]) begin
                    state_d = RD_STREAM;
                    k_d     = '0;
                end
            end
            RD_STREAM: begin
                if (!out_valid_q || out_ready_i) begin
                    out_data_d  = rdata[rd_bank_q];
                    out_valid_d = 1'b1;
                    out_last_d  = (k_q == '1);
                    k_d         = k_q + 1'b1;
                    if (k_q == '1) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        state_d           = full_q[~rd_bank_q] ? RD_STREAM : RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            p_q         <= '0;
            full_q      <= '0;
            ovf_q       <= 1'b0;
            rd_bank_q   <= 1'b0;
            state_q     <= RD_IDLE;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            p_q         <= p_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            rd_bank_q   <= rd_bank_d;
            state_q     <= state_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = out_data_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Scoreboard bench: frames are built in stored-index order, expected natural-order
// words are queued on issue, and a monitor pops them on every accepted output.
module tb_fft_bitrev_buffer;

    localparam int DW = 16;
    localparam int N  = 16;
    localparam int LG = 4;

    typedef logic [1:0][DW-1:0] cw_t;
    typedef struct {
        cw_t  data;
        logic last;
    } exp_t;

    logic clk_i       = 1'b0;
    logic rst         = 1'b1;
    logic in_valid_i  = 1'b0;
    logic out_ready_i = 1'b0;
    cw_t  a_i         = '0;
    cw_t  b_i         = '0;
    logic in_ready_o, out_valid_o, out_last_o, overflow_o;
    cw_t  out_data_o;

    int   checks   = 0;
    int   failures = 0;
    int   n_acc    = 0;
    int   ready_mode = 0;
    logic ready_val  = 1'b0;
    exp_t sbq[$];
    cw_t  frm [N];

    fft_bitrev_buffer #(.DATA_WIDTH(DW), .FRAC_BITS(15), .FFT_POINTS(N)) dut (
        .clk_i      (clk_i),
        .rst        (rst),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int i = 0; i < LG; i++) if ((k & (1 << i)) != 0) r += 1 << (LG - 1 - i);
        return r;
    endfunction

    task automatic mk_pat(input int off);
        for (int i = 0; i < N; i++) begin
            frm[i][0] = 16'(i + off);
            frm[i][1] = 16'(-(i + off));
        end
    endtask

    task automatic mk_rand();
        for (int i = 0; i < N; i++) frm[i] = cw_t'($urandom);
    endtask

    // Sends np pairs from frm; a completed accepted frame queues its natural-order output.
    task automatic send_pairs(input int np, input bit accept);
        for (int p = 0; p < np; p++) begin
            in_valid_i = 1'b1;
            a_i = frm[2*p];
            b_i = frm[2*p+1];
            @(posedge clk_i); #1;
        end
        in_valid_i = 1'b0;
        if (accept && np == N/2) begin
            for (int k = 0; k < N; k++) begin
                exp_t e;
                e.data = frm[brev(k)];
                e.last = (k == N-1);
                sbq.push_back(e);
            end
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk(sbq.size() == 0, nm, sbq.size(), 0);
        repeat (3) @(posedge clk_i);
        #1;
        chk(!out_valid_o, {nm, "_idle"}, out_valid_o, 0);
    endtask

    // Consumer ready: fixed, toggling or random.
    initial forever begin
        @(posedge clk_i); #2;
        case (ready_mode)
            0:       out_ready_i = ready_val;
            1:       out_ready_i = ~out_ready_i;
            default: out_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops on accept, checks hold while stalled.
    initial begin
        bit   stall;
        cw_t  held;
        exp_t e;
        stall = 0;
        held  = '0;
        forever begin
            @(negedge clk_i);
            if (rst) begin
                stall = 0;
            end else begin
                if (stall) chk(out_valid_o && out_data_o == held, "stall_hold", out_data_o, held);
                if (out_valid_o && out_ready_i) begin
                    if (sbq.size() == 0) begin
                        chk(1'b0, "unexpected_out", out_data_o, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk(out_data_o == e.data, "out_data", out_data_o, e.data);
                        chk(out_last_o == e.last, "out_last", out_last_o, e.last);
                    end
                    n_acc++;
                end
                stall = out_valid_o && !out_ready_i;
                held  = out_data_o;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        #1;
        chk(in_ready_o == 1'b1, "rst_in_ready", in_ready_o, 1);
        chk(out_valid_o == 1'b0, "rst_out_valid", out_valid_o, 0);
        chk(out_last_o == 1'b0, "rst_out_last", out_last_o, 0);
        chk(overflow_o == 1'b0, "rst_overflow", overflow_o, 0);
        chk(out_data_o == '0, "rst_out_data", out_data_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst = 1'b0;
        ready_val = 1'b1;
        @(posedge clk_i); #1;

        // 1: single frame, ready high, latency of two edges
        mk_pat(0);
        send_pairs(N/2, 1);
        chk(!out_valid_o, "lat_edge0", out_valid_o, 0);
        @(posedge clk_i); #1;
        chk(!out_valid_o, "lat_edge1", out_valid_o, 0);
        @(posedge clk_i); #1;
        chk(out_valid_o, "lat_edge2", out_valid_o, 1);
        drain("t1_drain");

        // 2: toggling ready
        ready_mode = 1;
        mk_pat(0);
        send_pairs(N/2, 1);
        drain("t2_drain");
        ready_mode = 0;

        // 3: two frames spaced by N/2 idle cycles
        mk_pat(0);
        send_pairs(N/2, 1);
        repeat (N/2) @(posedge clk_i);
        #1;
        mk_pat(100);
        send_pairs(N/2, 1);
        drain("t3_drain");
        chk(!overflow_o, "t3_no_overflow", overflow_o, 0);

        // 4: consumer stalled, third frame dropped
        ready_val = 1'b0;
        @(posedge clk_i); #1;
        mk_pat(0);
        send_pairs(N/2, 1);
        chk(in_ready_o, "t4_ready_after_f1", in_ready_o, 1);
        mk_pat(50);
        send_pairs(N/2, 1);
        chk(!in_ready_o, "t4_ready_after_f2", in_ready_o, 0);
        mk_pat(77);
        send_pairs(N/2, 0);
        chk(overflow_o, "t4_overflow", overflow_o, 1);
        ready_val = 1'b1;
        drain("t4_drain");
        chk(overflow_o, "t4_overflow_sticky", overflow_o, 1);

        // 5: reset mid-output (k=5) and mid-input (p=3)
        ready_val = 1'b0;
        @(posedge clk_i); #1;
        mk_pat(0);
        send_pairs(N/2, 1);
        mk_pat(30);
        send_pairs(3, 0);
        base = n_acc;
        ready_val = 1'b1;
        n = 0;
        while (n_acc - base < 5 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        ready_val = 1'b0;
        chk(n_acc - base == 5, "t5_reach_k5", n_acc - base, 5);
        rst = 1'b1;
        sbq.delete();
        #1;
        chk(!out_valid_o, "t5_rst_valid", out_valid_o, 0);
        chk(out_data_o == '0, "t5_rst_data", out_data_o, 0);
        chk(!out_last_o, "t5_rst_last", out_last_o, 0);
        chk(!overflow_o, "t5_rst_overflow", overflow_o, 0);
        chk(in_ready_o, "t5_rst_in_ready", in_ready_o, 1);
        repeat (2) @(posedge clk_i);
        #1;
        rst = 1'b0;
        ready_val = 1'b1;
        @(posedge clk_i); #1;
        mk_pat(200);
        send_pairs(N/2, 1);
        drain("t5_drain");

        // 6: extreme values at p=0
        mk_pat(0);
        frm[0][0] = 16'h7FFF; frm[0][1] = 16'h8000;
        frm[1][0] = 16'h8000; frm[1][1] = 16'h7FFF;
        send_pairs(N/2, 1);
        drain("t6_drain");

        // 7: random data with random consumer ready
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            mk_rand();
            n = 0;
            while (!in_ready_o && n < 200) begin
                @(posedge clk_i); #1;
                n++;
            end
            chk(in_ready_o, "t7_in_ready_wait", in_ready_o, 1);
            send_pairs(N/2, 1);
            repeat ($urandom_range(N/2, N)) @(posedge clk_i);
            #1;
        end
        ready_mode = 0;
        ready_val  = 1'b1;
        drain("t7_drain");
        chk(!overflow_o, "t7_no_overflow", overflow_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
